mastermind_game_ctrl: RTL
=========================

Name: mastermind_game_ctrl

Overview:
Game-logic stage that sits upstream of the game renderer and the video RAM. It consumes the debounced single-cycle button edge pulses and runs the MasterMind round: secret generation, guess entry, sequential black/white scoring, and win/loss detection. It publishes live state (state, row, cursor, current guess) for the renderer and segment display. It writes one history record per scored row into the VIDEORAM write port.

Parameters:
CODE_LEN, 4, pegs per code; legal range 1..5.
COLORS, 6, colours per peg; legal range 4..8; colour values 0..COLORS-1.
MAX_ROWS, 10, guesses allowed per game; legal range 1..16.

Ports:
CLK  in  1  game clock (CLK_PLL domain).
RST  in  1  synchronous, active-high reset.
BTN_NEXT  in  1  one-cycle pulse (S1 edge): advance colour of peg under cursor.
BTN_MOVE  in  1  one-cycle pulse (S2 edge): advance cursor.
BTN_CONFIRM  in  1  one-cycle pulse (S3 edge): start game / submit guess / restart.
SECRET_LD  in  1  debug load pulse: in IDLE, load SECRET_IN as the secret.
SECRET_IN  in  3*CODE_LEN  debug secret; peg i is bits [3i+2:3i].
STATE  out  3  0 IDLE, 1 ENTRY, 2 SCORE, 3 WRITE, 4 WON, 5 LOST.
ROW  out  4  current row index.
CURSOR  out  3  selected peg index.
GUESS  out  3*CODE_LEN  guess being edited; same packing as SECRET_IN.
BLACK  out  3  last scored black count.
WHITE  out  3  last scored white count.
SECRET  out  3*CODE_LEN  secret code; forced to 0 except in WON/LOST.
HIST_WEN  out  1  one-cycle write strobe to video RAM.
HIST_ADDR  out  4  equals ROW during the write.
HIST_WDATA  out  3*CODE_LEN+6  {WHITE, BLACK, GUESS}.

Behaviour:
- Reset: STATE=IDLE. ROW, CURSOR, GUESS, BLACK, WHITE, HIST_* and the internal secret all 0. LFSR=16'hACE1.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle in every state except during RST.
- IDLE:
  - SECRET_LD loads SECRET_IN. Otherwise BTN_CONFIRM captures the secret from the LFSR: peg i = LFSR[3i+2:3i], with COLORS subtracted when the value is >= COLORS.
  - Either event moves to ENTRY with ROW=0, CURSOR=0, GUESS=0.
  - SECRET_LD has priority over BTN_CONFIRM.
- ENTRY: at most one button acts per cycle; priority CONFIRM > MOVE > NEXT, and lower-priority pulses in the same cycle are dropped.
  - NEXT: GUESS[CURSOR] += 1, wrapping COLORS-1 -> 0.
  - MOVE: CURSOR += 1, wrapping CODE_LEN-1 -> 0.
  - CONFIRM: go to SCORE.
- SCORE: fixed duration of CODE_LEN+COLORS cycles; all buttons ignored.
  - Phase A (CODE_LEN cycles): one peg compared per cycle; black accumulates exact matches.
  - Phase B (COLORS cycles): one colour c per cycle; total += min(count of c in guess, count of c in secret).
  - On the last cycle, BLACK := black and WHITE := total - black (result is always >= 0).
- WRITE: 1 cycle. HIST_WEN=1, HIST_ADDR=ROW, HIST_WDATA={WHITE, BLACK, GUESS}.
  - Next state: WON if BLACK==CODE_LEN; else LOST if ROW==MAX_ROWS-1; else ENTRY with ROW+1, GUESS=0, CURSOR=0.
- Latency: CONFIRM accepted in cycle t puts HIST_WEN high in cycle t+CODE_LEN+COLORS+1. The next state is visible in cycle t+CODE_LEN+COLORS+2.
- WON/LOST: SECRET is driven out. BTN_CONFIRM goes to IDLE and clears ROW, CURSOR, GUESS, BLACK and WHITE. Other buttons are ignored.
- HIST_WEN is high only in WRITE, never more than one cycle per row.
- RST asserted in any state, including mid-SCORE, returns to the reset values on the next edge with no HIST write.

Test Plan:
1. Reset, then hold idle 5 cycles -> STATE=0, all outputs 0, HIST_WEN never high.
2. SECRET_LD with secret {1,2,3,4} (peg0..3), guess {1,3,2,0}, CONFIRM at cycle t -> HIST_WEN at t+11, HIST_ADDR=0, BLACK=1, WHITE=2, STATE=ENTRY, ROW=1, GUESS=0.
3. Secret {1,1,2,2}, guess {1,2,1,0} -> BLACK=1, WHITE=2. Guess {4,4,4,4} against secret {1,2,3,4} -> BLACK=1, WHITE=0.
4. Guess equal to secret on row 3 -> WRITE at ADDR=3, STATE=WON, SECRET visible. CONFIRM -> STATE=IDLE, ROW=0.
5. Ten wrong guesses -> last write at ADDR=9, STATE=LOST. BTN_NEXT pressed 6 times on peg0 -> colour wraps to 0. BTN_MOVE pressed 4 times -> CURSOR=0. Simultaneous NEXT+MOVE -> only CURSOR changes.
6. Assert RST two cycles into SCORE -> STATE=IDLE next cycle, no HIST_WEN. CONFIRM pressed during SCORE -> ignored.

Source files
------------

// File: rtl/mastermind_game_ctrl_if.sv
// Bundle between the MasterMind controller and its surroundings: button pulses,
// debug secret load, live game status and the video RAM history write port.
interface mastermind_game_ctrl_if #(
    parameter int CODE_LEN = 4
);
    localparam int GW = 3 * CODE_LEN;

    logic          BTN_NEXT;
    logic          BTN_MOVE;
    logic          BTN_CONFIRM;
    logic          SECRET_LD;
    logic [GW-1:0] SECRET_IN;

    logic [2:0]    STATE;
    logic [3:0]    ROW;
    logic [2:0]    CURSOR;
    logic [GW-1:0] GUESS;
    logic [2:0]    BLACK;
    logic [2:0]    WHITE;
    logic [GW-1:0] SECRET;

    logic          HIST_WEN;
    logic [3:0]    HIST_ADDR;
    logic [GW+5:0] HIST_WDATA;

    // The controller is the master: it owns status and history, consumes buttons.
    modport master (
        input  BTN_NEXT, BTN_MOVE, BTN_CONFIRM, SECRET_LD, SECRET_IN,
        output STATE, ROW, CURSOR, GUESS, BLACK, WHITE, SECRET,
        output HIST_WEN, HIST_ADDR, HIST_WDATA
    );

    modport slave (
        output BTN_NEXT, BTN_MOVE, BTN_CONFIRM, SECRET_LD, SECRET_IN,
        input  STATE, ROW, CURSOR, GUESS, BLACK, WHITE, SECRET,
        input  HIST_WEN, HIST_ADDR, HIST_WDATA
    );
endinterface

// File: rtl/mastermind_game_ctrl.sv
// MasterMind round controller: secret generation, guess entry, serial
// black/white scoring, win/loss detection and one history write per scored row.
module mastermind_game_ctrl #(
    parameter int CODE_LEN = 4,
    parameter int COLORS   = 6,
    parameter int MAX_ROWS = 10
) (
    input logic                    CLK,
    input logic                    RST,
    mastermind_game_ctrl_if.master bus
);
    localparam int GW = 3 * CODE_LEN;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_SCORE = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_WON   = 3'd4;
    localparam logic [2:0] ST_LOST  = 3'd5;

    localparam logic [3:0] PHASE_B    = 4'(CODE_LEN);
    localparam logic [3:0] SCORE_LAST = 4'(CODE_LEN + COLORS - 1);
    localparam logic [3:0] LAST_ROW   = 4'(MAX_ROWS - 1);
    localparam logic [2:0] LAST_PEG   = 3'(CODE_LEN - 1);
    localparam logic [2:0] LAST_COLOR = 3'(COLORS - 1);
    localparam logic [2:0] FULL_MATCH = 3'(CODE_LEN);
    localparam logic [3:0] COLORS4    = 4'(COLORS);

    logic [2:0]    state;
    logic [3:0]    row;
    logic [2:0]    cursor;
    logic [GW-1:0] guess;
    logic [GW-1:0] secret;
    logic [2:0]    black_r;
    logic [2:0]    white_r;
    logic [3:0]    score_cnt;
    logic [2:0]    black_acc;
    logic [2:0]    total_acc;
    logic [15:0]   lfsr;

    logic [15:0]   lfsr_next;
    logic [GW-1:0] lfsr_code;
    logic [GW-1:0] guess_inc;
    logic          peg_match;
    logic [2:0]    cur_color;
    logic [2:0]    cnt_guess;
    logic [2:0]    cnt_secret;
    logic [2:0]    color_min;
    logic [2:0]    total_next;
    logic          hist_wen;

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Fold each 3-bit LFSR slice into the colour range with a single subtraction.
    always_comb begin
        lfsr_code = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if ({1'b0, lfsr[3*i +: 3]} >= COLORS4)
                lfsr_code[3*i +: 3] = lfsr[3*i +: 3] - COLORS4[2:0];
            else
                lfsr_code[3*i +: 3] = lfsr[3*i +: 3];
        end
    end

    always_comb begin
        guess_inc = guess;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (3'(i) == cursor)
                guess_inc[3*i +: 3] = (guess[3*i +: 3] == LAST_COLOR) ? 3'd0
                                                                      : guess[3*i +: 3] + 3'd1;
        end
    end

    // Phase A uses score_cnt as a peg index, phase B as CODE_LEN + colour.
    always_comb begin
        peg_match  = 1'b0;
        cnt_guess  = '0;
        cnt_secret = '0;
        cur_color  = 3'(score_cnt - PHASE_B);
        for (int i = 0; i < CODE_LEN; i++) begin
            if (score_cnt == 4'(i) && guess[3*i +: 3] == secret[3*i +: 3])
                peg_match = 1'b1;
            if (guess[3*i +: 3] == cur_color)
                cnt_guess = cnt_guess + 3'd1;
            if (secret[3*i +: 3] == cur_color)
                cnt_secret = cnt_secret + 3'd1;
        end
        color_min  = (cnt_guess < cnt_secret) ? cnt_guess : cnt_secret;
        total_next = total_acc + color_min;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            row       <= '0;
            cursor    <= '0;
            guess     <= '0;
            secret    <= '0;
            black_r   <= '0;
            white_r   <= '0;
            score_cnt <= '0;
            black_acc <= '0;
            total_acc <= '0;
            lfsr      <= 16'hACE1;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                ST_IDLE: begin
                    if (bus.SECRET_LD || bus.BTN_CONFIRM) begin
                        secret <= bus.SECRET_LD ? bus.SECRET_IN : lfsr_code;
                        row    <= '0;
                        cursor <= '0;
                        guess  <= '0;
                        state  <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (bus.BTN_CONFIRM) begin
                        score_cnt <= '0;
                        black_acc <= '0;
                        total_acc <= '0;
                        state     <= ST_SCORE;
                    end else if (bus.BTN_MOVE) begin
                        cursor <= (cursor == LAST_PEG) ? 3'd0 : cursor + 3'd1;
                    end else if (bus.BTN_NEXT) begin
                        guess <= guess_inc;
                    end
                end
                ST_SCORE: begin
                    if (score_cnt < PHASE_B)
                        black_acc <= black_acc + {2'b00, peg_match};
                    else
                        total_acc <= total_next;
                    // The last cycle is always in phase B, so black_acc is already final.
                    if (score_cnt == SCORE_LAST) begin
                        black_r <= black_acc;
                        white_r <= total_next - black_acc;
                        state   <= ST_WRITE;
                    end else begin
                        score_cnt <= score_cnt + 4'd1;
                    end
                end
                ST_WRITE: begin
                    if (black_r == FULL_MATCH) begin
                        state <= ST_WON;
                    end else if (row == LAST_ROW) begin
                        state <= ST_LOST;
                    end else begin
                        row    <= row + 4'd1;
                        guess  <= '0;
                        cursor <= '0;
                        state  <= ST_ENTRY;
                    end
                end
                ST_WON, ST_LOST: begin
                    if (bus.BTN_CONFIRM) begin
                        row     <= '0;
                        cursor  <= '0;
                        guess   <= '0;
                        black_r <= '0;
                        white_r <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hist_wen       = (state == ST_WRITE);
    assign bus.STATE      = state;
    assign bus.ROW        = row;
    assign bus.CURSOR     = cursor;
    assign bus.GUESS      = guess;
    assign bus.BLACK      = black_r;
    assign bus.WHITE      = white_r;
    assign bus.SECRET     = (state == ST_WON || state == ST_LOST) ? secret : '0;
    assign bus.HIST_WEN   = hist_wen;
    assign bus.HIST_ADDR  = hist_wen ? row : 4'd0;
    assign bus.HIST_WDATA = hist_wen ? {white_r, black_r, guess} : '0;
endmodule
